// File: rtl/barret_sched_1733_pkg.sv
// Shared constants and FSM state type for the mod-1733 Barrett reduction engine.
package barret_1733_pkg;

  localparam int unsigned Q    = 1733;
  localparam int unsigned K    = 11;
  localparam int unsigned MU   = 2420;  // floor(2^22 / Q)
  localparam int unsigned A_W  = 21;
  localparam int unsigned R_W  = 11;
  localparam int unsigned P_W  = 22;
  localparam int unsigned D_W  = 13;    // a - t*Q is always < 3Q

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL1,
    S_MUL2,
    S_SUB,
    S_CORR,
    S_DONE
  } state_t;

endpackage

// File: rtl/barret_sched_1733_rr_arb.sv
// Round-robin grant over NREQ requesters; the search starts at rr, which
// advances past the granted requester on each accepted grant.
module barret_rr_arb #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic            adv,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   grant_idx
);

  logic [PW-1:0] rr;
  logic [PW-1:0] pick_idx;
  logic          hit;
  int unsigned   j;

  always_comb begin
    pick_idx = '0;
    hit      = 1'b0;
    j        = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (32'(rr) + i) % NREQ;
      if (!hit && req[j[PW-1:0]]) begin
        hit      = 1'b1;
        pick_idx = j[PW-1:0];
      end
    end
    grant = '0;
    if (en && hit) grant[pick_idx] = 1'b1;
  end

  assign grant_idx = pick_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= '0;
    end else if (adv) begin
      rr <= (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

endmodule

// File: rtl/barret_sched_1733.sv
// Shared mod-1733 Barrett reducer with round-robin request arbitration.
// Define BARRET_SCHED_FAST_CORR_EN for a single-cycle final correction.
module barret_sched_1733
  import barret_1733_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     in_valid,
  input  logic [NREQ*21-1:0]  in_data,
  output logic [NREQ-1:0]     in_ready,
  output logic                out_valid,
  output logic [10:0]         out_data,
  output logic [IDW-1:0]      out_id,
  input  logic                out_ready
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nx;
  logic [A_W-1:0]  a;
  logic [IDW-1:0]  id;
  logic [P_W-1:0]  prod;
  logic [D_W-1:0]  r;

  logic [NREQ-1:0] grant;
  logic [PW-1:0]   gidx;
  logic            fire;
  logic [A_W-1:0]  sel_a;
  logic [10:0]     mul_a;
  logic [11:0]     mul_b;
  logic [P_W-1:0]  mul_p;

  barret_rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .en        (state == S_IDLE && rst_n),
    .adv       (fire),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign in_ready  = grant;
  assign fire      = |grant;
  assign out_valid = (state == S_DONE);
  assign out_data  = r[R_W-1:0];
  assign out_id    = id;

  always_comb begin
    sel_a = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gidx == PW'(i)) sel_a = in_data[i*A_W +: A_W];
    end
  end

  // One multiplier: q*MU in MUL1, then t*Q in MUL2 with t taken from the stored product.
  always_comb begin
    mul_a = {1'b0, a[A_W-1:K]};
    mul_b = 12'(MU);
    if (state == S_MUL2) begin
      mul_a = prod[P_W-1:K];
      mul_b = 12'(Q);
    end
  end

  assign mul_p = {11'b0, mul_a} * {10'b0, mul_b};

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (fire) state_nx = S_MUL1;
      S_MUL1: state_nx = S_MUL2;
      S_MUL2: state_nx = S_SUB;
      S_SUB:  state_nx = S_CORR;
`ifdef BARRET_SCHED_FAST_CORR_EN
      S_CORR: state_nx = S_DONE;
`else
      S_CORR: if (r < D_W'(Q)) state_nx = S_DONE;
`endif
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a    <= '0;
      id   <= '0;
      prod <= '0;
      r    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (fire) begin
            a  <= sel_a;
            id <= IDW'(gidx);
          end
        end
        S_MUL1, S_MUL2: prod <= mul_p;
        S_SUB:  r <= D_W'({1'b0, a} - prod);
        S_CORR: begin
`ifdef BARRET_SCHED_FAST_CORR_EN
          if (r >= D_W'(2 * Q))  r <= r - D_W'(2 * Q);
          else if (r >= D_W'(Q)) r <= r - D_W'(Q);
`else
          if (r >= D_W'(Q)) r <= r - D_W'(Q);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barret_sched_1733.sv
// Scoreboard bench for barret_sched_1733 with four requesters.
module tb_barret_sched_1733;

  localparam int NREQ = 4;
  localparam int IDW  = 3;
  localparam int Q    = 1733;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   in_valid;
  logic [NREQ*21-1:0] in_data;
  logic [NREQ-1:0]   in_ready;
  logic              out_valid;
  logic [10:0]       out_data;
  logic [IDW-1:0]    out_id;
  logic              out_ready;

  always #5 clk = ~clk;

  barret_sched_1733 #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  typedef struct {
    int id;
    int val;
  } exp_t;

  exp_t            sbq[$];
  int              errors = 0;
  int              checks = 0;
  int              rr_m   = 0;
  int              last_grant = -1;
  int              n_out  = 0;
  logic [NREQ-1:0] fire_mask;
  logic            hold_prev = 1'b0;
  logic [10:0]     hold_data;
  logic [IDW-1:0]  hold_id;

`ifdef BARRET_SCHED_FAST_CORR_EN
  localparam int LAT0 = 4, LAT1 = 4, LAT2 = 4;
`else
  localparam int LAT0 = 4, LAT1 = 5, LAT2 = 6;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Samples at the falling edge: handshakes seen here complete on the next rising edge.
  task automatic monitor();
    logic [NREQ-1:0] expg;
    int g;
    fire_mask = '0;
    if (!rst_n) begin
      chk("ready_in_reset", 32'(in_ready), 0);
      sbq.delete();
      rr_m = 0;
      hold_prev = 1'b0;
      return;
    end
    if (hold_prev) begin
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_data", 32'(out_data), 32'(hold_data));
      chk("hold_id", 32'(out_id), 32'(hold_id));
    end
    if (out_valid) chk("ready_busy", 32'(in_ready), 0);
    if (in_ready != '0) begin
      expg = '0;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (rr_m + k) % NREQ;
        if (g < 0 && in_valid[j]) g = j;
      end
      if (g >= 0) expg[g] = 1'b1;
      chk("grant", 32'(in_ready), 32'(expg));
      fire_mask = in_valid & in_ready;
      for (int k = 0; k < NREQ; k++) if (fire_mask[k]) last_grant = k;
      if (g >= 0) begin
        sbq.push_back('{g, int'(in_data[g*21 +: 21]) % Q});
        rr_m = (g + 1) % NREQ;
      end
    end
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", 32'(out_valid), 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_data", 32'(out_data), 32'(e.val));
        chk("out_id", 32'(out_id), 32'(e.id));
        chk("out_range", 32'(out_data < 11'(Q)), 1);
        n_out++;
      end
    end
    hold_prev = out_valid && !out_ready;
    hold_data = out_data;
    hold_id   = out_id;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 40) begin
      step();
      n++;
    end
    chk("drain", 32'(sbq.size()), 0);
  endtask

  task automatic single(input int idx, input int data, input int exp_lat);
    int lat;
    in_valid[idx] = 1'b1;
    in_data[idx*21 +: 21] = 21'(data);
    step();
    chk("accepted", 32'(fire_mask[idx]), 1);
    in_valid[idx] = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    drain();
  endtask

  initial begin
    int ops[5];
    int lats[5];
    int ng;
    int n;
    int remaining;
    int n_before;

    rst_n     = 1'b0;
    in_valid  = '1;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_id", 32'(out_id), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    step();
    step();
    in_valid = '0;
    rst_n = 1'b1;
    step();

    // Directed single requests, including the all-ones operand and modulus boundaries.
    ops  = '{2097151, 0, 1732, 1733, 3466};
    lats = '{LAT2, LAT0, LAT0, LAT1, LAT1};
    for (int i = 0; i < 5; i++) single(i % NREQ, ops[i], lats[i]);

    // Round-robin alternation from a freshly reset pointer.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    in_data[0 +: 21]  = 21'd123456;
    in_data[21 +: 21] = 21'd654321;
    in_valid = 4'b0011;
    ng = 0;
    n = 0;
    while (ng < 4 && n < 60) begin
      step();
      n++;
      if (fire_mask != '0) begin
        chk("alt_order", 32'(last_grant), 32'(ng % 2));
        in_data[last_grant*21 +: 21] = 21'($urandom_range(0, 2097151));
        ng++;
      end
    end
    chk("alt_count", 32'(ng), 4);
    in_valid = '0;
    drain();

    // Consumer stall in DONE with a competing request pending.
    out_ready = 1'b0;
    in_valid[2] = 1'b1;
    in_data[2*21 +: 21] = 21'd2097151;
    step();
    in_valid[2] = 1'b0;
    in_valid[1] = 1'b1;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("stall_data", 32'(out_data), 221);
    chk("stall_id", 32'(out_id), 2);
    repeat (10) step();
    chk("stall_valid_end", 32'(out_valid), 1);
    in_valid[1] = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset during SUB discards the operation and restarts arbitration at requester 0.
    in_valid[0] = 1'b1;
    in_data[0 +: 21] = 21'd99999;
    step();
    in_valid[0] = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 0);
    in_data[0 +: 21]  = 21'd1000000;
    in_data[21 +: 21] = 21'd2000000;
    in_valid = 4'b0011;
    step();
    rst_n = 1'b1;
    step();
    chk("rst_regrant", 32'(fire_mask), 32'(4'b0001));
    in_valid = '0;
    drain();

    // Random traffic on all requesters with random consumer backpressure.
    remaining = 400;
    n_before = n_out;
    n = 0;
    while ((remaining > 0 || in_valid != '0 || sbq.size() != 0 || out_valid) && n < 20000) begin
      step();
      n++;
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (fire_mask[i] || !in_valid[i]) begin
          if (remaining > 0 && $urandom_range(0, 1) == 1) begin
            in_valid[i] = 1'b1;
            in_data[i*21 +: 21] = 21'($urandom_range(0, 2097151));
            remaining--;
          end else begin
            in_valid[i] = 1'b0;
          end
        end
      end
    end
    chk("random_served", 32'(n_out - n_before), 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
